// File: rtl/divider_4xn.sv
// Sequential restoring divider: (N+4)-bit dividend / 4-bit divisor, one quotient bit per clock.
// Optional macro DIV4XN_ZERO_DETECT_EN short-circuits a zero divisor and raises div_zero.
module divider_4xn #(
    parameter int unsigned N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N+3:0] dividend,
    input  logic [3:0]   divisor,
    output logic         ready,
    output logic         done,
    output logic [N+3:0] quotient,
    output logic [3:0]   remainder,
    output logic         div_zero
);

    localparam int unsigned W  = N + 4;
    localparam int unsigned CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    dvd_q, dvd_d;
    logic [3:0]      dvs_q, dvs_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      rem_q, rem_d;
    logic [W-1:0]    quo_q, quo_d;
    logic [3:0]      remo_q, remo_d;

    logic [4:0]      r_shift;
    logic            r_ge;
    logic [3:0]      r_next;

`ifdef DIV4XN_ZERO_DETECT_EN
    logic            dz_q, dz_d;
`endif

    // Quotient bits shift into the vacated LSBs of the dividend register.
    always_comb begin
        r_shift = {rem_q, dvd_q[W-1]};
        r_ge    = (r_shift >= {1'b0, dvs_q});
        r_next  = r_ge ? 4'(r_shift - {1'b0, dvs_q}) : r_shift[3:0];
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        remo_d  = remo_q;
`ifdef DIV4XN_ZERO_DETECT_EN
        dz_d    = dz_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    cnt_d   = CW'(W);
                    rem_d   = '0;
                    state_d = RUN;
`ifdef DIV4XN_ZERO_DETECT_EN
                    if (divisor == 4'd0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        remo_d  = '0;
                        dz_d    = 1'b1;
                    end else begin
                        dz_d    = 1'b0;
                    end
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                dvd_d = {dvd_q[W-2:0], r_ge};
                rem_d = r_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    quo_d   = {dvd_q[W-2:0], r_ge};
                    remo_d  = r_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            remo_q  <= '0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            remo_q  <= remo_d;
        end
    end

`ifdef DIV4XN_ZERO_DETECT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dz_q <= 1'b0;
        else        dz_q <= dz_d;
    end
    assign div_zero = dz_q;
`else
    assign div_zero = 1'b0;
`endif

    assign ready     = (state_q == IDLE) || (state_q == DONE);
    assign done      = (state_q == DONE);
    assign quotient  = quo_q;
    assign remainder = remo_q;

endmodule
